// File: rtl/dmem_pkg.sv
// dmem_bridge shared types: FSM states, error causes, access sizes.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } dmem_state_t;

   // Error cause of the last transaction; ERR_NONE means a clean completion.
   typedef enum logic [2:0] {
      ERR_NONE,
      ERR_MISALIGN,
      ERR_BUSERR,
      ERR_TIMEOUT,
      ERR_RDWR
   } dmem_err_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   function automatic logic misaligned(input logic [1:0] size,
                                       input logic [1:0] lsb);
      return ((size == SIZE_WORD) && (lsb != 2'b00)) ||
             ((size == SIZE_HALF) && lsb[0]);
   endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Saturating 8-bit WAIT-cycle counter; expired on the last allowed cycle.
module dmem_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (reset_i || clear)
         cnt_q <= '0;
      else if (enable && (cnt_q != 8'hFF))
         cnt_q <= cnt_q + 8'd1;
   end

   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// mem_stage to req/ack data bus bridge: stalls the pipeline while a
// transaction is in flight and flags misalign/bus error/timeout/rd+wr.
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] daddr_i,
   input  logic [31:0] dwdata_i,
   input  logic [1:0]  dsize_i,
   input  logic [3:0]  dbe_i,
   input  logic        drd_i,
   input  logic        dwr_i,
   output logic [31:0] drdata_o,
   output logic        mem_stall_o,
   output logic        dmem_err_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   input  logic        bus_ack_i,
   input  logic        bus_err_i,
   input  logic [31:0] bus_rdata_i
);

   dmem_state_t state_q, state_d;
   dmem_err_t   cause_q, cause_d;
   logic [31:0] rdata_q, rdata_d;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic        request;
   logic        latch;
   logic        in_wait;
   logic        expired;

   assign request = drd_i | dwr_i;
   assign in_wait = (state_q == WAIT);

   dmem_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .clear  (!in_wait),
      .enable (in_wait),
      .expired(expired)
   );

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      rdata_d = rdata_q;
      latch   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (request) begin
               latch = 1'b1;
               if (misaligned(dsize_i, daddr_i[1:0])) begin
                  state_d = DONE;
                  cause_d = ERR_MISALIGN;
                  if (!dwr_i)
                     rdata_d = ERR_RDATA;
               end else begin
                  state_d = WAIT;
                  cause_d = (drd_i && dwr_i) ? ERR_RDWR : ERR_NONE;
               end
            end
         end
         WAIT: begin
            // Slave error wins over a simultaneous ack.
            if (bus_err_i) begin
               state_d = DONE;
               cause_d = ERR_BUSERR;
               if (!we_q)
                  rdata_d = ERR_RDATA;
            end else if (bus_ack_i) begin
               state_d = DONE;
               if (!we_q)
                  rdata_d = bus_rdata_i;
            end else if (expired) begin
               state_d = DONE;
               cause_d = ERR_TIMEOUT;
               if (!we_q)
                  rdata_d = ERR_RDATA;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cause_q <= ERR_NONE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         rdata_q <= rdata_d;
      end
   end

   // rd+wr together is issued as a write.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (latch) begin
         we_q    <= dwr_i;
         addr_q  <= {daddr_i[31:2], 2'b00};
         wdata_q <= dwdata_i;
         be_q    <= dwr_i ? dbe_i : 4'b0000;
      end
   end

   assign bus_req_o   = in_wait;
   assign bus_we_o    = in_wait & we_q;
   assign bus_addr_o  = in_wait ? addr_q : '0;
   assign bus_wdata_o = in_wait ? wdata_q : '0;
   assign bus_be_o    = in_wait ? be_q : '0;
   assign mem_stall_o = in_wait | ((state_q == IDLE) & request);
   assign dmem_err_o  = (state_q == DONE) && (cause_q != ERR_NONE);
   assign drdata_o    = rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized bench for dmem_bridge against a transaction-level model.
module tb_dmem_bridge;
   import dmem_pkg::*;

   localparam int TB_T = 4;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [31:0] daddr_i, dwdata_i;
   logic [1:0]  dsize_i;
   logic [3:0]  dbe_i;
   logic        drd_i, dwr_i;
   logic [31:0] drdata_o;
   logic        mem_stall_o, dmem_err_o;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_ack_i, bus_err_i;
   logic [31:0] bus_rdata_i;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_rdata;

   dmem_bridge #(
      .TIMEOUT_CYCLES(TB_T),
      .ERR_RDATA     (ERRD)
   ) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .daddr_i    (daddr_i),
      .dwdata_i   (dwdata_i),
      .dsize_i    (dsize_i),
      .dbe_i      (dbe_i),
      .drd_i      (drd_i),
      .dwr_i      (dwr_i),
      .drdata_o   (drdata_o),
      .mem_stall_o(mem_stall_o),
      .dmem_err_o (dmem_err_o),
      .bus_req_o  (bus_req_o),
      .bus_we_o   (bus_we_o),
      .bus_addr_o (bus_addr_o),
      .bus_wdata_o(bus_wdata_o),
      .bus_be_o   (bus_be_o),
      .bus_ack_i  (bus_ack_i),
      .bus_err_i  (bus_err_i),
      .bus_rdata_i(bus_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge. ack_at/err_at: WAIT-cycle index of the
   // response, -1 for never.
   task automatic run_txn(input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic [3:0] be,
                          input int ack_at, input int err_at,
                          input logic [31:0] rdat);
      logic mis, we, err;
      int   nwait, first;
      we  = wr;
      mis = (sz == SIZE_WORD && addr[1:0] != 2'b00) ||
            (sz == SIZE_HALF && addr[0]);
      if (mis) begin
         nwait = 0;
         err   = 1'b1;
      end else begin
         first = 1000;
         if (err_at >= 0) first = err_at;
         if (ack_at >= 0 && ack_at < first) first = ack_at;
         if (first < TB_T) begin
            nwait = first + 1;
            err   = (err_at == first) || (rd && wr);
         end else begin
            nwait = TB_T;
            err   = 1'b1;
         end
      end
      if (!we) begin
         if (err) exp_rdata = ERRD;
         else     exp_rdata = rdat;
      end

      drd_i = rd; dwr_i = wr; daddr_i = addr;
      dwdata_i = wd; dsize_i = sz; dbe_i = be;
      bus_ack_i = 1'b0; bus_err_i = 1'b0;
      #1 check("idle_ctl", {bus_req_o, mem_stall_o, dmem_err_o}, 3'b010);
      @(negedge clk_i);
      for (int w = 0; w < nwait; w++) begin
         bus_ack_i   = (w == ack_at);
         bus_err_i   = (w == err_at);
         bus_rdata_i = (w == ack_at) ? rdat : $urandom;
         #1;
         check("wait_ctl", {bus_req_o, mem_stall_o, dmem_err_o, bus_we_o},
               {1'b1, 1'b1, 1'b0, we});
         check("wait_addr", bus_addr_o, {addr[31:2], 2'b00});
         check("wait_be", bus_be_o, we ? be : 4'b0000);
         if (we) check("wait_wdata", bus_wdata_o, wd);
         @(negedge clk_i);
      end
      bus_ack_i = 1'b0; bus_err_i = 1'b0;
      #1;
      check("done_ctl", {bus_req_o, mem_stall_o, dmem_err_o},
            {1'b0, 1'b0, err});
      check("done_rdata", drdata_o, exp_rdata);
      @(negedge clk_i);
      drd_i = 1'b0; dwr_i = 1'b0;
      #1 check("post_idle", {bus_req_o, mem_stall_o, dmem_err_o}, 3'b000);
   endtask

   initial begin
      logic rd, wr;
      int   r, ack_at, err_at;
      logic [31:0] a;
      reset_i = 1'b1;
      daddr_i = '0; dwdata_i = '0; dsize_i = '0; dbe_i = '0;
      drd_i = 1'b0; dwr_i = 1'b0;
      bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
      exp_rdata = '0;
      repeat (2) @(negedge clk_i);
      check("reset_outs",
            {mem_stall_o, dmem_err_o, bus_req_o, bus_we_o, bus_be_o},
            8'h00);
      check("reset_rdata", drdata_o, 32'h0);
      check("reset_addr", {bus_addr_o, bus_wdata_o}, 64'h0);
      reset_i = 1'b0;
      @(negedge clk_i);

      run_txn(1, 0, 32'h100, 32'h0, SIZE_WORD, 4'hF, 1, -1, 32'hA5A5_1234);
      run_txn(0, 1, 32'h203, 32'h7700_0000, SIZE_BYTE, 4'b1000, 0, -1, 32'h0);
      run_txn(1, 0, 32'h102, 32'h0, SIZE_WORD, 4'hF, 0, -1, 32'h5555_5555);
      run_txn(1, 0, 32'h0F0, 32'h0, SIZE_WORD, 4'hF, 0, -1, 32'h0BAD_F00D);
      run_txn(1, 0, 32'h400, 32'h0, SIZE_WORD, 4'hF, -1, -1, 32'h0);
      run_txn(1, 0, 32'h050, 32'h0, SIZE_WORD, 4'hF, 0, -1, 32'h1357_9BDF);
      run_txn(1, 0, 32'h500, 32'h0, SIZE_WORD, 4'hF, 1, 1, 32'h1234_5678);
      run_txn(1, 0, 32'h060, 32'h0, SIZE_HALF, 4'hF, 2, -1, 32'h2468_ACE0);
      run_txn(0, 1, 32'h101, 32'hCAFE_0000, SIZE_HALF, 4'b0110, 0, -1, 32'h0);
      run_txn(1, 1, 32'h080, 32'h0102_0304, SIZE_WORD, 4'hF, 0, -1, 32'hFFFF);
      run_txn(0, 1, 32'h090, 32'h0A0B_0C0D, SIZE_WORD, 4'hF, -1, -1, 32'h0);

      // Stray responses while idle must be ignored.
      bus_ack_i = 1'b1; bus_err_i = 1'b1; bus_rdata_i = 32'h9999_0000;
      @(negedge clk_i);
      #1 check("stray_idle", {bus_req_o, mem_stall_o, dmem_err_o}, 3'b000);
      check("stray_rdata", drdata_o, exp_rdata);
      bus_ack_i = 1'b0; bus_err_i = 1'b0;
      @(negedge clk_i);

      // Reset in the middle of WAIT, then a late ack.
      drd_i = 1'b1; daddr_i = 32'h300; dsize_i = SIZE_WORD;
      @(negedge clk_i);
      #1 check("rst_wait", bus_req_o, 1'b1);
      reset_i = 1'b1; drd_i = 1'b0;
      @(negedge clk_i);
      #1 check("rst_idle", {bus_req_o, mem_stall_o, dmem_err_o}, 3'b000);
      exp_rdata = '0;
      reset_i = 1'b0;
      bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
      @(negedge clk_i);
      #1 check("late_ack", {bus_req_o, mem_stall_o, dmem_err_o}, 3'b000);
      @(negedge clk_i);
      bus_ack_i = 1'b0;
      #1 check("late_rdata", drdata_o, exp_rdata);
      @(negedge clk_i);

      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 19);
         rd = (r < 9) || (r >= 18);
         wr = (r >= 9);
         ack_at = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
         err_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 5) : -1;
         a = $urandom;
         run_txn(rd, wr, a, $urandom, 2'($urandom_range(0, 2)),
                 4'($urandom), ack_at, err_at, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
